clock_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It conditions the two active-low front-panel buttons (modify_n, plus_n) and runs the RUN/SET mode state machine. It issues single-cycle edit commands to the hour, minute and second counters, gates the 1 Hz advance while the user is editing, and drives the blanking signal that makes the field being edited blink on the seven-segment display.

---
 rtl/clock_set_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: button conditioning, RUN/SET mode FSM,
// edit strobes with auto-repeat, 1 Hz gating and field blinking.
module clock_set_debounce #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != level) begin
        if (cnt == DEB_M1) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module clock_set_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 8,
  parameter int BLINK_HALF   = 10,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       modify_n,
  input  logic       plus_n,
  input  logic       sec_tick,
  output logic [1:0] mode,
  output logic       run_en,
  output logic       sec_adv,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blank
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_M1 = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] BLK_M1 = CNT_W'(BLINK_HALF - 1);

  mode_t            mode_q;
  mode_t            mode_d;
  logic             mod_lvl;
  logic             plus_lvl;
  logic             mod_prev;
  logic             plus_prev;
  logic             mod_press;
  logic             plus_press;
  logic             rpt_act;
  logic             rpt_act_d;
  logic             rpt_first;
  logic             rpt_first_d;
  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_cnt_d;
  logic [CNT_W-1:0] blk_cnt;
  logic [CNT_W-1:0] blk_cnt_d;
  logic             blank_d;
  logic             inc_hr_d;
  logic             inc_min_d;
  logic             clr_sec_d;
  logic             edit;
  logic             fire;

  clock_set_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_deb_mod (
    .clk  (clk),
    .reset(reset),
    .raw  (modify_n),
    .level(mod_lvl)
  );

  clock_set_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_deb_plus (
    .clk  (clk),
    .reset(reset),
    .raw  (plus_n),
    .level(plus_lvl)
  );

  assign mod_press  = mod_prev & ~mod_lvl;
  assign plus_press = plus_prev & ~plus_lvl;
  assign fire = (rpt_cnt == (rpt_first ? DLY_M1 : RATE_M1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= RUN;
      run_en    <= 1'b1;
      sec_adv   <= 1'b0;
      inc_hr    <= 1'b0;
      inc_min   <= 1'b0;
      clr_sec   <= 1'b0;
      blank     <= 1'b0;
      mod_prev  <= 1'b1;
      plus_prev <= 1'b1;
      rpt_act   <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
      blk_cnt   <= '0;
    end else begin
      mode_q    <= mode_d;
      run_en    <= (mode_d == RUN);
      sec_adv   <= sec_tick & run_en;
      inc_hr    <= inc_hr_d;
      inc_min   <= inc_min_d;
      clr_sec   <= clr_sec_d;
      blank     <= blank_d;
      mod_prev  <= mod_lvl;
      plus_prev <= plus_lvl;
      rpt_act   <= rpt_act_d;
      rpt_first <= rpt_first_d;
      rpt_cnt   <= rpt_cnt_d;
      blk_cnt   <= blk_cnt_d;
    end
  end

  // Modify has priority; a plus event in the same cycle is dropped.
  always_comb begin
    mode_d      = mode_q;
    inc_hr_d    = 1'b0;
    inc_min_d   = 1'b0;
    clr_sec_d   = 1'b0;
    rpt_act_d   = rpt_act;
    rpt_first_d = rpt_first;
    rpt_cnt_d   = rpt_cnt;
    if (mod_press) begin
      mode_d    = mode_t'(mode_q + 2'd1);
      rpt_act_d = 1'b0;
    end else if (plus_press) begin
      unique case (mode_q)
        SET_HR: begin
          inc_hr_d    = 1'b1;
          rpt_act_d   = 1'b1;
          rpt_first_d = 1'b1;
          rpt_cnt_d   = '0;
        end
        SET_MIN: begin
          inc_min_d   = 1'b1;
          rpt_act_d   = 1'b1;
          rpt_first_d = 1'b1;
          rpt_cnt_d   = '0;
        end
        SET_SEC: clr_sec_d = 1'b1;
        RUN:     rpt_act_d = 1'b0;
      endcase
    end else if (rpt_act) begin
      if (plus_lvl) begin
        rpt_act_d = 1'b0;
      end else if (fire) begin
        inc_hr_d    = (mode_q == SET_HR);
        inc_min_d   = (mode_q == SET_MIN);
        rpt_first_d = 1'b0;
        rpt_cnt_d   = '0;
      end else begin
        rpt_cnt_d = rpt_cnt + 1'b1;
      end
    end
  end

  assign edit = inc_hr_d | inc_min_d | clr_sec_d;

  // Restarting the blink phase keeps a freshly edited value visible.
  always_comb begin
    blank_d   = blank;
    blk_cnt_d = blk_cnt;
    if (mode_d == RUN || mode_d != mode_q || edit) begin
      blank_d   = 1'b0;
      blk_cnt_d = '0;
    end else if (blk_cnt == BLK_M1) begin
      blank_d   = ~blank;
      blk_cnt_d = '0;
    end else begin
      blk_cnt_d = blk_cnt + 1'b1;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed button/tick stimulus
// queues expected events; a monitor compares them as they appear.
module tb_clock_set_ctrl;

  localparam int K_HR  = 0;
  localparam int K_MIN = 1;
  localparam int K_SEC = 2;
  localparam int K_ADV = 3;
  localparam int K_MODE = 10;

  typedef struct {
    int cyc;
    int kind;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       modify_n = 1'b1;
  logic       plus_n = 1'b1;
  logic       sec_tick = 1'b0;
  logic [1:0] mode;
  logic       run_en;
  logic       sec_adv;
  logic       inc_hr;
  logic       inc_min;
  logic       clr_sec;
  logic       blank;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  evt_t exp_q[$];

  clock_set_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .modify_n(modify_n),
    .plus_n  (plus_n),
    .sec_tick(sec_tick),
    .mode    (mode),
    .run_en  (run_en),
    .sec_adv (sec_adv),
    .inc_hr  (inc_hr),
    .inc_min (inc_min),
    .clr_sec (clr_sec),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d",
               name, cyc, got, want);
    end
  endtask

  task automatic push(input int c, input int k);
    evt_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k);
    evt_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_evt", cyc * 100 + k, -1);
    end else begin
      e = exp_q.pop_front();
      check("evt", cyc * 100 + k, e.cyc * 100 + e.kind);
    end
  endtask

  logic [1:0] prev_mode = 2'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mode != prev_mode) begin
          observe(K_MODE + int'(mode));
          check("run_en", int'(run_en), int'(mode == 2'd0));
        end
        if (inc_hr) observe(K_HR);
        if (inc_min) observe(K_MIN);
        if (clr_sec) observe(K_SEC);
        if (sec_adv) observe(K_ADV);
        if (inc_hr | inc_min | clr_sec) begin
          check("blank_on_edit", int'(blank), 0);
          check("onehot", int'(inc_hr) + int'(inc_min)
                + int'(clr_sec), 1);
        end
      end
      prev_mode = mode;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input bit in_run);
    if (in_run) push(cyc + 1, K_ADV);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic modify(input int m);
    push(cyc + 7, K_MODE + m);
    modify_n = 1'b0;
    wait_cyc(10);
    modify_n = 1'b1;
  endtask

  initial begin
    int n;
    int m;
    wait_cyc(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mode", int'(mode), 0);
    check("rst_run_en", int'(run_en), 1);
    check("rst_blank", int'(blank), 0);
    check("rst_pulses", int'({sec_adv, inc_hr, inc_min, clr_sec}), 0);
    mon_en = 1'b1;
    tick(1'b1);
    wait_cyc(3);
    tick(1'b1);
    wait_cyc(3);

    for (int i = 1; i <= 4; i++) begin
      modify(i % 4);
      if (i == 1) tick(1'b0);
      wait_cyc(19);
      check("run_en_step", int'(run_en), int'(i == 4));
    end
    tick(1'b1);
    wait_cyc(3);

    m = cyc + 7;
    modify(1);
    while (cyc < m + 9) @(negedge clk);
    check("blink_lo", int'(blank), 0);
    @(negedge clk);
    check("blink_hi", int'(blank), 1);
    wait_cyc(20);

    plus_n = 1'b0;
    wait_cyc(3);
    plus_n = 1'b1;
    wait_cyc(30);
    push(cyc + 7, K_HR);
    plus_n = 1'b0;
    wait_cyc(10);
    plus_n = 1'b1;
    wait_cyc(40);

    push(cyc + 7, K_MODE + 2);
    modify_n = 1'b0;
    plus_n   = 1'b0;
    wait_cyc(10);
    modify_n = 1'b1;
    plus_n   = 1'b1;
    wait_cyc(40);

    n = cyc;
    push(n + 7, K_MIN);
    push(n + 27, K_MIN);
    push(n + 35, K_MIN);
    push(n + 43, K_MIN);
    plus_n = 1'b0;
    wait_cyc(40);
    plus_n = 1'b1;
    wait_cyc(40);

    modify(3);
    wait_cyc(20);
    push(cyc + 7, K_SEC);
    plus_n = 1'b0;
    wait_cyc(40);
    plus_n = 1'b1;
    wait_cyc(30);

    modify(0);
    wait_cyc(20);
    modify(1);
    wait_cyc(20);
    modify(2);
    wait_cyc(20);

    n = cyc;
    push(n + 7, K_MIN);
    push(n + 25, K_MODE);
    plus_n = 1'b0;
    while (cyc < n + 24) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cyc == n + 40) plus_n = 1'b1;
      check("post_rst_blank", int'(blank), 0);
      check("post_rst_mode", int'(mode), 0);
      @(negedge clk);
    end
    plus_n = 1'b1;
    wait_cyc(20);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d: got running, want done", cyc);
    $fatal(1, "timeout");
  end

endmodule
